// File: rtl/sync_rx_fifo_pkg.sv
// rtl/sync_rx_fifo_pkg.sv - shared link defaults and helpers for the receive FIFO
package sync_rx_fifo_pkg;

  // Default link word width (BusData), common to sender, receiver and FIFO
  localparam int DEF_B = 16;

  // Width of an occupancy counter able to hold 0..depth
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x B register array, one sync write port, one async read port
module fifo_mem #(
  parameter int B     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [B-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [B-1:0]  rdata
);

  logic [B-1:0] mem [DEPTH];

  // Write port: data words carry no reset, contents are qualified by count
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port is combinational so the oldest word falls through immediately
  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_rx_fifo.sv
// rtl/sync_rx_fifo.sv - receive-side elastic buffer with receiver back-pressure
module sync_rx_fifo
  import sync_rx_fifo_pkg::*;
#(
  parameter  int B     = DEF_B,
  parameter  int DEPTH = 8,
  parameter  int SLACK = 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [B-1:0] wr_data,
  output logic         rx_en,
  output logic         rd_vld,
  output logic [B-1:0] rd_data,
  input  logic         rd_rdy,
  output logic [CW-1:0] count,
  output logic         ovf
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  // rx_en must drop early enough that SLACK in-flight words still fit
  localparam logic [CW-1:0] EN_LIMIT = CW'(DEPTH - SLACK);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic          rd;
  logic          wr_acc;
  logic          full;

  assign full   = (count == FULL_CNT);
  assign rd_vld = (count != '0);
  assign rd     = rd_vld & rd_rdy;
  // A full FIFO still accepts a word when a read frees a slot in the same cycle
  assign wr_acc = wr_vld & (~full | rd);

  // Next occupancy: simultaneous write and read cancel out
  always_comb begin
    count_next = count;
    if (wr_acc && !rd)
      count_next = count + CW'(1);
    else if (!wr_acc && rd)
      count_next = count - CW'(1);
  end

  // Pointers, occupancy, receiver enable and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rx_en  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd)     rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      rx_en <= (count_next < EN_LIMIT);
      if (wr_vld && !wr_acc) ovf <= 1'b1;
    end
  end

  fifo_mem #(
    .B     (B),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_sync_rx_fifo.sv
// tb/tb_sync_rx_fifo.sv - directed scoreboard bench for sync_rx_fifo
module tb_sync_rx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_vld = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rx_en;
  logic        rd_vld;
  logic [15:0] rd_data;
  logic        rd_rdy = 1'b0;
  logic [3:0]  count;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  logic [15:0] q[$];
  logic        m_ovf = 1'b0;
  logic [15:0] last_pop = '0;

  sync_rx_fifo #(.B(16), .DEPTH(8), .SLACK(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_vld  (wr_vld),
    .wr_data (wr_data),
    .rx_en   (rx_en),
    .rd_vld  (rd_vld),
    .rd_data (rd_data),
    .rd_rdy  (rd_rdy),
    .count   (count),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check output word against the scoreboard head,
  // advance the reference model at the edge, then check the registered state.
  task automatic cycle(input logic wv, input logic [15:0] wd, input logic rr);
    logic do_rd;
    logic do_acc;
    @(negedge clk);
    wr_vld = wv; wr_data = wd; rd_rdy = rr;
    #1;
    if (q.size() > 0) begin
      check("rd_vld_hi", {31'd0, rd_vld}, 32'd1);
      check("rd_data", {16'd0, rd_data}, {16'd0, q[0]});
    end else begin
      check("rd_vld_lo", {31'd0, rd_vld}, 32'd0);
    end
    do_rd  = (q.size() > 0) && rr;
    do_acc = wv && ((q.size() < 8) || do_rd);
    @(posedge clk);
    #1;
    if (do_rd) last_pop = q.pop_front();
    if (do_acc) q.push_back(wd);
    if (wv && !do_acc) m_ovf = 1'b1;
    check("count", {28'd0, count}, q.size());
    check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    check("rx_en", {31'd0, rx_en}, {31'd0, (q.size() < 7)});
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst = 1'b1; wr_vld = 1'b0; rd_rdy = 1'b0;
    #1;
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_rd_vld", {31'd0, rd_vld}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_rx_en", {31'd0, rx_en}, 32'd0);
    q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_rx_en_lo", {31'd0, rx_en}, 32'd0);
    @(posedge clk);
    #1;
    check("rel_rx_en_hi", {31'd0, rx_en}, 32'd1);
  endtask

  initial begin
    int sent;
    int budget;
    #1;
    check("init_count", {28'd0, count}, 32'd0);
    check("init_rx_en", {31'd0, rx_en}, 32'd0);
    pulse_reset();

    // Test 1: reset with five words stored
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0);
    check("pre_rst_count", {28'd0, count}, 32'd5);
    pulse_reset();

    // Test 2: three words held, then drained
    cycle(1'b1, 16'h0001, 1'b0);
    cycle(1'b1, 16'h0002, 1'b0);
    cycle(1'b1, 16'h0003, 1'b0);
    check("t2_count", {28'd0, count}, 32'd3);
    check("t2_head", {16'd0, rd_data}, 32'h0001);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1);
    check("t2_last", {16'd0, last_pop}, 32'h0003);

    // Test 3: fill to eight with back-to-back writes
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'hA000 + 16'(i), 1'b0);
    check("t3_full", {28'd0, count}, 32'd8);
    check("t3_rx_en", {31'd0, rx_en}, 32'd0);

    // Test 4: write into full FIFO without read is dropped
    cycle(1'b1, 16'hDEAD, 1'b0);
    check("t4_ovf", {31'd0, ovf}, 32'd1);
    check("t4_count", {28'd0, count}, 32'd8);

    // Test 5: full with simultaneous write and read, then drain
    cycle(1'b1, 16'hBEEF, 1'b1);
    check("t5_count", {28'd0, count}, 32'd8);
    for (int i = 0; i < 9; i++) cycle(1'b0, 16'h0000, 1'b1);
    check("t5_last", {16'd0, last_pop}, 32'hBEEF);
    check("t5_empty", {28'd0, count}, 32'd0);

    // Test 6: clear overflow, stream 20 words with the consumer always ready
    pulse_reset();
    sent = 0;
    budget = 0;
    while ((sent < 20 || q.size() > 0) && budget < 200) begin
      if (sent < 20 && rx_en) begin
        cycle(1'b1, 16'h5000 + 16'(sent), 1'b1);
        sent++;
      end else begin
        cycle(1'b0, 16'h0000, 1'b1);
      end
      check("t6_count_le1", {31'd0, (count <= 4'd1)}, 32'd1);
      budget++;
    end
    check("t6_budget", {31'd0, (budget < 200)}, 32'd1);
    check("t6_sent", sent, 32'd20);
    check("t6_last", {16'd0, last_pop}, 32'h5013);
    check("t6_ovf", {31'd0, ovf}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
